// File: rtl/matmul_batch_scheduler_pkg.sv
// Shared types for the matmul batch scheduler: FSM states, handshake phases, latched batch config.
package matmul_batch_scheduler_pkg;

  localparam int VEC_IDX_W = 16;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CHECK   = 4'd1,
    S_LD_TRIG = 4'd2,
    S_LD_WAIT = 4'd3,
    S_MM_TRIG = 4'd4,
    S_MM_WAIT = 4'd5,
    S_RD_TRIG = 4'd6,
    S_RD_WAIT = 4'd7,
    S_NEXT    = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_HOLD = 2'd1,
    HS_WAIT = 2'd2
  } hs_state_t;

  typedef struct packed {
    logic [VEC_IDX_W-1:0] num_vectors;
    logic                 cds_en;
    logic                 reset_en;
    logic                 readout_en;
    logic [2:0]           num_bits;
    logic [4:0]           pulse_multiplier;
  } cfg_t;

endpackage

// File: rtl/matmul_batch_scheduler_if.sv
// Host-side config/status and engine trigger/idle signals of the batch scheduler.
interface matmul_batch_scheduler_if;
  import matmul_batch_scheduler_pkg::*;

  logic                 start;
  logic                 abort;
  logic [VEC_IDX_W-1:0] num_vectors;
  logic                 cds_en;
  logic                 reset_en;
  logic                 readout_en;
  logic [2:0]           num_bits;
  logic [4:0]           pulse_multiplier;
  logic                 busy;
  logic                 done;
  logic                 aborted;
  logic [VEC_IDX_W-1:0] vectors_done;
  logic                 load_trigger;
  logic [VEC_IDX_W-1:0] load_addr;
  logic                 load_idle;
  logic                 mm_trigger;
  logic                 mm_cds;
  logic                 mm_reset;
  logic [2:0]           mm_num_bits;
  logic [4:0]           mm_pulse_multiplier;
  logic                 mm_idle;
  logic                 rd_trigger;
  logic                 rd_idle;

  modport master (
    output start, abort, num_vectors, cds_en, reset_en, readout_en, num_bits, pulse_multiplier,
    output load_idle, mm_idle, rd_idle,
    input  busy, done, aborted, vectors_done, load_trigger, load_addr,
    input  mm_trigger, mm_cds, mm_reset, mm_num_bits, mm_pulse_multiplier, rd_trigger
  );

  modport slave (
    input  start, abort, num_vectors, cds_en, reset_en, readout_en, num_bits, pulse_multiplier,
    input  load_idle, mm_idle, rd_idle,
    output busy, done, aborted, vectors_done, load_trigger, load_addr,
    output mm_trigger, mm_cds, mm_reset, mm_num_bits, mm_pulse_multiplier, rd_trigger
  );

endinterface

// File: rtl/matmul_batch_scheduler_trig_handshake.sv
// Trigger an engine: hold trigger until its idle falls, then report completion when idle rises again.
module trig_handshake
  import matmul_batch_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic target_idle,
  output logic trigger,
  output logic complete
);

  hs_state_t hs_q, hs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hs_q <= HS_IDLE;
    else        hs_q <= hs_d;
  end

  // Idle still high while holding is the engine's stale level, never completion.
  always_comb begin
    hs_d     = hs_q;
    complete = 1'b0;
    case (hs_q)
      HS_IDLE: if (go) hs_d = HS_HOLD;
      HS_HOLD: if (!target_idle) hs_d = HS_WAIT;
      HS_WAIT: if (target_idle) begin
        complete = 1'b1;
        hs_d     = HS_IDLE;
      end
      default: hs_d = HS_IDLE;
    endcase
  end

  assign trigger = (hs_q == HS_HOLD);

endmodule

// File: rtl/matmul_batch_scheduler.sv
// Runs a batch of load -> matmul -> optional readout per vector, with abort honoured between vectors.
module matmul_batch_scheduler
  import matmul_batch_scheduler_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  matmul_batch_scheduler_if.slave bus
);

  state_t               state_q, state_d;
  cfg_t                 cfg_q;
  logic [VEC_IDX_W-1:0] vec_cnt_q;
  logic                 busy_q, done_q, aborted_q;
  logic                 start_acc, abort_hit;
  logic                 ld_go, mm_go, rd_go;
  logic                 ld_complete, mm_complete, rd_complete;

  assign start_acc = (state_q == S_IDLE) && bus.start;

  always_comb begin
    state_d   = state_q;
    abort_hit = 1'b0;
    case (state_q)
      S_IDLE:    if (bus.start) state_d = S_CHECK;
      S_CHECK: begin
        if (vec_cnt_q == cfg_q.num_vectors) begin
          state_d = S_DONE;
        end else if (bus.abort) begin
          state_d   = S_DONE;
          abort_hit = 1'b1;
        end else begin
          state_d = S_LD_TRIG;
        end
      end
      S_LD_TRIG: if (!bus.load_idle) state_d = S_LD_WAIT;
      S_LD_WAIT: if (ld_complete) state_d = S_MM_TRIG;
      S_MM_TRIG: if (!bus.mm_idle) state_d = S_MM_WAIT;
      S_MM_WAIT: if (mm_complete) state_d = cfg_q.readout_en ? S_RD_TRIG : S_NEXT;
      S_RD_TRIG: if (!bus.rd_idle) state_d = S_RD_WAIT;
      S_RD_WAIT: if (rd_complete) state_d = S_NEXT;
      S_NEXT:    state_d = S_CHECK;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign ld_go = (state_d == S_LD_TRIG) && (state_q != S_LD_TRIG);
  assign mm_go = (state_d == S_MM_TRIG) && (state_q != S_MM_TRIG);
  assign rd_go = (state_d == S_RD_TRIG) && (state_q != S_RD_TRIG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cfg_q     <= '0;
      vec_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      if (start_acc) begin
        cfg_q <= '{num_vectors:      bus.num_vectors,
                   cds_en:           bus.cds_en,
                   reset_en:         bus.reset_en,
                   readout_en:       bus.readout_en,
                   num_bits:         bus.num_bits,
                   pulse_multiplier: bus.pulse_multiplier};
        vec_cnt_q <= '0;
        aborted_q <= 1'b0;
      end else begin
        if (abort_hit)           aborted_q <= 1'b1;
        if (state_d == S_NEXT)   vec_cnt_q <= vec_cnt_q + 1'b1;
      end
    end
  end

  trig_handshake u_ld_hs (.clk(clk), .rst_n(rst_n), .go(ld_go), .target_idle(bus.load_idle),
                          .trigger(bus.load_trigger), .complete(ld_complete));
  trig_handshake u_mm_hs (.clk(clk), .rst_n(rst_n), .go(mm_go), .target_idle(bus.mm_idle),
                          .trigger(bus.mm_trigger), .complete(mm_complete));
  trig_handshake u_rd_hs (.clk(clk), .rst_n(rst_n), .go(rd_go), .target_idle(bus.rd_idle),
                          .trigger(bus.rd_trigger), .complete(rd_complete));

  // Helper config stays on the latched values for the whole batch.
  assign bus.busy                = busy_q;
  assign bus.done                = done_q;
  assign bus.aborted             = aborted_q;
  assign bus.vectors_done        = vec_cnt_q;
  assign bus.load_addr           = vec_cnt_q;
  assign bus.mm_cds              = cfg_q.cds_en;
  assign bus.mm_reset            = cfg_q.reset_en;
  assign bus.mm_num_bits         = cfg_q.num_bits;
  assign bus.mm_pulse_multiplier = cfg_q.pulse_multiplier;

endmodule

// File: tb/tb_matmul_batch_scheduler.sv
// Bench for matmul_batch_scheduler: modelled engines, table-driven batches, random batches, corner sequences.
module tb_matmul_batch_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matmul_batch_scheduler_if bus();

  matmul_batch_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Engine timing: trigger -> idle low takes lat cycles, idle stays low bsy cycles.
  int lat_l = 1, bsy_l = 1, lat_m = 1, bsy_m = 1, lat_r = 1, bsy_r = 1;
  int exp_lm = 1;

  int busy_cnt = 0, done_cnt = 0, ld_cnt = 0, mm_cnt = 0, rd_cnt = 0, hold_bad = 0, mm_hold = 0;
  logic ld_p = 1'b0, mm_p = 1'b0, rd_p = 1'b0;
  logic [15:0] ld_addrs[$];

  typedef struct {
    int nv; bit ro; int lat; int bsy;
    int exp_cyc; int exp_rd;
  } vec_t;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  // Reference: each vector costs CHECK + NEXT plus every engine's trigger and busy time.
  function automatic int model_cycles(input int nv, input bit ro, input int ll, bl, lm, bm, lr, br);
    return nv * (2 + ll + bl + lm + bm + (ro ? (lr + br) : 0)) + 2;
  endfunction

  initial begin
    bus.load_idle = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bus.load_trigger && bus.load_idle) begin
        repeat (lat_l - 1) @(posedge clk);
        #1 bus.load_idle = 1'b0;
        repeat (bsy_l) @(posedge clk);
        #1 bus.load_idle = 1'b1;
      end
    end
  end

  initial begin
    bus.mm_idle = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bus.mm_trigger && bus.mm_idle) begin
        repeat (lat_m - 1) @(posedge clk);
        #1 bus.mm_idle = 1'b0;
        repeat (bsy_m) @(posedge clk);
        #1 bus.mm_idle = 1'b1;
      end
    end
  end

  initial begin
    bus.rd_idle = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bus.rd_trigger && bus.rd_idle) begin
        repeat (lat_r - 1) @(posedge clk);
        #1 bus.rd_idle = 1'b0;
        repeat (bsy_r) @(posedge clk);
        #1 bus.rd_idle = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    busy_cnt = busy_cnt + int'(bus.busy);
    done_cnt = done_cnt + int'(bus.done);
    if (bus.load_trigger && !ld_p) begin
      ld_cnt++;
      ld_addrs.push_back(bus.load_addr);
    end
    if (bus.mm_trigger && !mm_p) mm_cnt++;
    if (bus.rd_trigger && !rd_p) rd_cnt++;
    if (bus.mm_trigger) mm_hold++;
    else begin
      if (mm_p && mm_hold != exp_lm) hold_bad++;
      mm_hold = 0;
    end
    ld_p = bus.load_trigger;
    mm_p = bus.mm_trigger;
    rd_p = bus.rd_trigger;
  end

  task automatic drive_start(input int nv, input bit ro, cds, rs, input logic [2:0] nb, input logic [4:0] pm);
    bus.num_vectors      = 16'(nv);
    bus.readout_en       = ro;
    bus.cds_en           = cds;
    bus.reset_en         = rs;
    bus.num_bits         = nb;
    bus.pulse_multiplier = pm;
    bus.start            = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 4000 && bus.busy; i++) @(negedge clk);
    chk({tag, "_ends"}, bus.busy, 0);
  endtask

  task automatic run_batch(input string tag, input int nv, input bit ro,
                           input int ll, bl, lm, bm, lr, br, input int exp_cyc, exp_rd);
    int b0, d0, l0, m0, r0, h0, a0, bad;
    logic cds, rs;
    logic [2:0] nb;
    logic [4:0] pm;
    cds = 1'($urandom); rs = 1'($urandom); nb = 3'($urandom); pm = 5'($urandom);
    lat_l = ll; bsy_l = bl; lat_m = lm; bsy_m = bm; lat_r = lr; bsy_r = br; exp_lm = lm;
    @(negedge clk); #1;
    b0 = busy_cnt; d0 = done_cnt; l0 = ld_cnt; m0 = mm_cnt; r0 = rd_cnt; h0 = hold_bad; a0 = ld_addrs.size();
    @(negedge clk);
    drive_start(nv, ro, cds, rs, nb, pm);
    // Inputs move after start; latched config must win.
    bus.num_vectors = 16'(nv + 3); bus.readout_en = ~ro; bus.cds_en = ~cds;
    bus.reset_en = ~rs; bus.num_bits = ~nb; bus.pulse_multiplier = ~pm;
    wait_idle(tag);
    @(negedge clk); #1;
    chk({tag, "_busy_cycles"}, busy_cnt - b0, exp_cyc);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_ld_trigs"}, ld_cnt - l0, nv);
    chk({tag, "_mm_trigs"}, mm_cnt - m0, nv);
    chk({tag, "_rd_trigs"}, rd_cnt - r0, exp_rd);
    chk({tag, "_mm_hold"}, hold_bad - h0, 0);
    chk({tag, "_vectors_done"}, bus.vectors_done, nv);
    chk({tag, "_aborted"}, bus.aborted, 0);
    chk({tag, "_cfg"}, {bus.mm_cds, bus.mm_reset, bus.mm_num_bits, bus.mm_pulse_multiplier},
        {cds, rs, nb, pm});
    bad = 0;
    for (int k = 0; k < nv; k++)
      if (ld_addrs.size() <= a0 + k || ld_addrs[a0 + k] != 16'(k)) bad++;
    chk({tag, "_addr_seq"}, bad, 0);
  endtask

  initial begin
    vec_t tbl[6];
    int d0, r0, l0, b0;
    tbl[0] = '{nv:3, ro:1'b1, lat:1, bsy:5, exp_cyc:62, exp_rd:3};
    tbl[1] = '{nv:0, ro:1'b1, lat:1, bsy:1, exp_cyc:2,  exp_rd:0};
    tbl[2] = '{nv:2, ro:1'b0, lat:2, bsy:3, exp_cyc:26, exp_rd:0};
    tbl[3] = '{nv:1, ro:1'b1, lat:1, bsy:1, exp_cyc:10, exp_rd:1};
    tbl[4] = '{nv:4, ro:1'b0, lat:1, bsy:1, exp_cyc:26, exp_rd:0};
    tbl[5] = '{nv:2, ro:1'b1, lat:3, bsy:2, exp_cyc:36, exp_rd:2};

    bus.start = 1'b0; bus.abort = 1'b0; bus.num_vectors = '0; bus.cds_en = 1'b0;
    bus.reset_en = 1'b0; bus.readout_en = 1'b0; bus.num_bits = '0; bus.pulse_multiplier = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.busy, bus.done, bus.aborted, bus.vectors_done, bus.load_trigger,
        bus.load_addr, bus.mm_trigger, bus.mm_cds, bus.mm_reset, bus.mm_num_bits,
        bus.mm_pulse_multiplier, bus.rd_trigger}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty batch: CHECK then DONE, no triggers.
    @(negedge clk); #1; l0 = ld_cnt;
    drive_start(0, 1'b1, 1'b0, 1'b0, 3'd1, 5'd1);
    chk("nv0_busy_c1", bus.busy, 1);
    chk("nv0_done_c1", bus.done, 0);
    @(negedge clk);
    chk("nv0_done_c2", bus.done, 1);
    @(negedge clk);
    chk("nv0_done_fall", {bus.done, bus.busy}, 0);
    chk("nv0_no_trig", ld_cnt - l0, 0);

    // Start latency into the first load trigger.
    lat_l = 1; bsy_l = 2; lat_m = 1; bsy_m = 2; lat_r = 1; bsy_r = 2; exp_lm = 1;
    @(negedge clk);
    drive_start(1, 1'b0, 1'b0, 1'b0, 3'd2, 5'd2);
    chk("lat_busy_k", bus.busy, 1);
    chk("lat_ldtrig_k", bus.load_trigger, 0);
    @(negedge clk);
    chk("lat_ldtrig_k1", bus.load_trigger, 1);
    wait_idle("lat");

    foreach (tbl[i])
      run_batch($sformatf("tbl%0d", i), tbl[i].nv, tbl[i].ro, tbl[i].lat, tbl[i].bsy,
                tbl[i].lat, tbl[i].bsy, tbl[i].lat, tbl[i].bsy, tbl[i].exp_cyc, tbl[i].exp_rd);

    for (int n = 0; n < 8; n++) begin
      int nv, ll, bl, lm, bm, lr, br;
      bit ro;
      nv = $urandom_range(0, 5); ro = 1'($urandom);
      ll = $urandom_range(1, 3); bl = $urandom_range(1, 6);
      lm = $urandom_range(1, 3); bm = $urandom_range(1, 6);
      lr = $urandom_range(1, 3); br = $urandom_range(1, 6);
      run_batch($sformatf("rnd%0d", n), nv, ro, ll, bl, lm, bm, lr, br,
                model_cycles(nv, ro, ll, bl, lm, bm, lr, br), ro ? nv : 0);
    end

    // Abort while vector 1 of 4 is in MM_WAIT.
    lat_l = 1; bsy_l = 5; lat_m = 1; bsy_m = 5; lat_r = 1; bsy_r = 5; exp_lm = 1;
    @(negedge clk); #1; r0 = rd_cnt; l0 = ld_cnt;
    drive_start(4, 1'b1, 1'b0, 1'b0, 3'd1, 5'd1);
    for (int i = 0; i < 1000 && !(bus.vectors_done == 16'd1 && !bus.mm_idle && !bus.mm_trigger); i++)
      @(negedge clk);
    chk("abort_reach_mmwait", {bus.vectors_done == 16'd1, bus.mm_idle, bus.mm_trigger}, 3'b100);
    bus.abort = 1'b1;
    for (int i = 0; i < 1000 && !bus.done; i++) @(negedge clk);
    chk("abort_done", bus.done, 1);
    chk("abort_flag", bus.aborted, 1);
    chk("abort_vectors_done", bus.vectors_done, 2);
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_flag_held", {bus.aborted, bus.busy}, 2'b10);
    #1;
    chk("abort_rd_trigs", rd_cnt - r0, 2);
    chk("abort_ld_trigs", ld_cnt - l0, 2);

    // Reset during RD_WAIT: outputs clear at once, no done pulse, clean restart.
    bsy_r = 6;
    @(negedge clk); #1; d0 = done_cnt;
    drive_start(3, 1'b1, 1'b1, 1'b1, 3'd5, 5'd17);
    for (int i = 0; i < 1000 && !(!bus.rd_idle && !bus.rd_trigger && bus.busy); i++) @(negedge clk);
    chk("rst_reach_rdwait", {bus.rd_idle, bus.rd_trigger, bus.busy}, 3'b001);
    rst_n = 1'b0;
    #1;
    chk("rst_outputs_mid", {bus.busy, bus.done, bus.aborted, bus.vectors_done, bus.load_trigger,
        bus.load_addr, bus.mm_trigger, bus.mm_cds, bus.mm_reset, bus.mm_num_bits,
        bus.mm_pulse_multiplier, bus.rd_trigger}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    chk("rst_no_done", done_cnt - d0, 0);
    run_batch("post_rst", 2, 1'b1, 1, 2, 1, 2, 1, 2, model_cycles(2, 1'b1, 1, 2, 1, 2, 1, 2), 2);

    // Start re-pulsed and num_bits changed while busy.
    lat_l = 1; bsy_l = 3; lat_m = 1; bsy_m = 3; lat_r = 1; bsy_r = 3; exp_lm = 1;
    @(negedge clk); #1; b0 = busy_cnt; l0 = ld_cnt;
    drive_start(3, 1'b0, 1'b0, 1'b1, 3'd5, 5'd9);
    for (int i = 0; i < 1000 && bus.vectors_done != 16'd1; i++) @(negedge clk);
    chk("repulse_reach", bus.vectors_done, 1);
    bus.start = 1'b1; bus.num_bits = 3'd2; bus.num_vectors = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    chk("repulse_num_bits", bus.mm_num_bits, 5);
    wait_idle("repulse");
    @(negedge clk); #1;
    chk("repulse_vectors_done", bus.vectors_done, 3);
    chk("repulse_ld_trigs", ld_cnt - l0, 3);
    chk("repulse_busy_cycles", busy_cnt - b0, model_cycles(3, 1'b0, 1, 3, 1, 3, 1, 3));
    chk("repulse_cfg_hold", {bus.mm_num_bits, bus.mm_pulse_multiplier, bus.mm_reset}, {3'd5, 5'd9, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=%0d", $time, 2000000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
